// File: rtl/muldiv_fu_pkg.sv
// rtl/muldiv_fu_pkg.sv - op/state encodings and operand-sign helpers shared by muldiv_fu
package muldiv_fu_pkg;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MUL only needs the low product bits, which are sign-agnostic
  function automatic logic src1_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
  endfunction

  function automatic logic src2_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] mcand_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    acc_o   = acc_i;
    lo_o    = lo_i;
    sum     = {1'b0, acc_i} + {1'b0, mcand_i};
    shifted = {acc_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, mcand_i};
    if (is_div) begin
      // remainder stays below the divisor, so diff's top bit is a clean borrow
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shifted[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b0};
      end
    end else if (lo_i[0]) begin
      {acc_o, lo_o} = {sum, lo_i[XLEN-1:1]};
    end else begin
      {acc_o, lo_o} = {1'b0, acc_i, lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_fu.sv
// rtl/muldiv_fu.sv - iterative RV M-extension multiply/divide unit
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for the MUL* ops.
module muldiv_fu
  import muldiv_fu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_t   state;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, lo_q, mcand_q, result_q;
  logic            out_valid_q;

  logic            s1_neg, s2_neg, res_neg, div_zero, div_ovf, fast_mul;
  logic [XLEN-1:0] abs1, abs2, special_res, fast_res, acc_nxt, lo_nxt;
  logic [XLEN-1:0] div_sel, fix_res;
  logic [2*XLEN-1:0] prod_raw, prod_fix;

  assign in_ready_o  = (state == ST_IDLE) && !flush_i;
  assign busy_o      = (state != ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

  assign s1_neg   = src1_signed(op_i) & src1_i[XLEN-1];
  assign s2_neg   = src2_signed(op_i) & src2_i[XLEN-1];
  assign abs1     = s1_neg ? -src1_i : src1_i;
  assign abs2     = s2_neg ? -src2_i : src2_i;
  assign res_neg  = op_is_rem(op_i) ? s1_neg : (s1_neg ^ s2_neg);
  assign div_zero = op_is_div(op_i) && (src2_i == '0);
  assign div_ovf  = op_is_div(op_i) && src2_signed(op_i) && (src2_i == '1) &&
                    (src1_i == {1'b1, {(XLEN-1){1'b0}}});
  assign special_res = div_zero ? (op_is_rem(op_i) ? src1_i : '1)
                                : (op_is_rem(op_i) ? '0 : src1_i);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  assign fa       = {{XLEN{s1_neg}}, src1_i};
  assign fb       = {{XLEN{s2_neg}}, src2_i};
  assign fprod    = fa * fb;
  assign fast_mul = !op_is_div(op_i);
  assign fast_res = (op_i == MULDIV_OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc_i   (acc_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_nxt),
    .lo_o    (lo_nxt)
  );

  // acc_q:lo_q holds the product, or remainder:quotient, as magnitudes
  always_comb begin
    prod_raw = {acc_q, lo_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    div_sel  = op_is_rem(op_q) ? acc_q : lo_q;
    if (neg_q) div_sel = -div_sel;
    case (op_q)
      MULDIV_OP_MUL:                                   fix_res = prod_fix[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      default:                                         fix_res = div_sel;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op_q        <= MULDIV_OP_MUL;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            op_q  <= op_i;
            neg_q <= res_neg;
            if (fast_mul) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (div_zero || div_ovf) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              acc_q   <= '0;
              lo_q    <= abs1;
              mcand_q <= abs2;
              cnt_q   <= CW'(XLEN);
              state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result_q    <= fix_res;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_fu.sv
// tb/tb_muldiv_fu.sv - scoreboard bench for muldiv_fu against an arithmetic reference model
module tb_muldiv_fu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hold_low = 1'b0;
  bit rand_bp = 1'b0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  muldiv_fu #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 34;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Holds in_valid until accepted; leaves the caller on the negedge after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit push);
    int waited = 0;
    in_valid_i = 1'b1;
    op_i = op;
    src1_i = a;
    src2_i = b;
    #1;
    while (!in_ready_o && waited < 300) begin
      @(negedge clock); #1; waited++;
    end
    if (!in_ready_o) begin
      chk(1'b0, "accept_timeout", 64'(in_ready_o), 64'd1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    if (push) begin
      exp_q.push_back(expv);
      lat_q.push_back(exp_lat(op, a, b));
      acc_q.push_back(cyc);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clock); w++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      out_ready_i = hold_low ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    bit          held = 1'b0;
    logic [31:0] held_res = '0;
    int          first_cyc = 0;
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        held = 1'b0;
        continue;
      end
      if (out_valid_o) begin
        if (!held) first_cyc = cyc;
        else chk(result_o == held_res, "result_hold", 64'(result_o), 64'(held_res));
        chk(!in_ready_o, "in_ready_in_done", 64'(in_ready_o), 64'd0);
        if (out_ready_i) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_output", 64'(result_o), 64'd0);
          end else begin
            logic [31:0] e;
            int l, a;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            a = acc_q.pop_front();
            chk(result_o == e, "result", 64'(result_o), 64'(e));
            chk(first_cyc - a + 1 == l, "latency", 64'(first_cyc - a + 1), 64'(l));
          end
        end
      end
      held = out_valid_o && !out_ready_i;
      held_res = result_o;
    end
  end

  initial begin
    logic [31:0] a, b, r0;
    logic [2:0]  op;
    int w;

    repeat (2) @(negedge clock);
    #1;
    chk(out_valid_o == 1'b0, "reset_out_valid", 64'(out_valid_o), 64'd0);
    chk(result_o == 32'h0, "reset_result", 64'(result_o), 64'd0);
    chk(busy_o == 1'b0, "reset_busy", 64'(busy_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk(in_ready_o == 1'b1, "post_reset_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clock);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue(3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(3'd7, 32'd5, 32'd0, 32'd5, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    drain();

    // Backpressure: result parked in DONE for five cycles
    @(posedge clock); hold_low = 1'b1;
    @(negedge clock);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    w = 0;
    while (!out_valid_o && w < 100) begin @(negedge clock); #1; w++; end
    chk(out_valid_o, "bp_valid_timeout", 64'(out_valid_o), 64'd1);
    r0 = result_o;
    repeat (5) @(negedge clock);
    #1;
    chk(result_o == r0 && out_valid_o, "bp_stable", 64'(result_o), 64'(r0));
    chk(in_ready_o == 1'b0, "bp_in_ready_low", 64'(in_ready_o), 64'd0);
    @(posedge clock); hold_low = 1'b0;
    @(posedge clock);
    @(negedge clock); #2;
    chk(busy_o == 1'b0 && in_ready_o == 1'b1, "bp_release_idle", 64'({busy_o, in_ready_o}), 64'b01);
    @(negedge clock);

    // Flush at CALC cycle 10, then an immediate new operation
    issue(3'd4, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (9) @(negedge clock);
    flush_i = 1'b1;
    #1;
    chk(in_ready_o == 1'b0, "flush_in_ready", 64'(in_ready_o), 64'd0);
    @(negedge clock);
    flush_i = 1'b0;
    #1;
    chk(busy_o == 1'b0 && out_valid_o == 1'b0, "flush_idle", 64'({busy_o, out_valid_o}), 64'd0);
    chk(in_ready_o == 1'b1, "flush_ready_next", 64'(in_ready_o), 64'd1);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    drain();

    // Flush beats a simultaneous offer
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    op_i = 3'd5;
    src1_i = 32'd9;
    src2_i = 32'd0;
    @(negedge clock);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk(busy_o == 1'b0 && out_valid_o == 1'b0, "flush_beats_valid", 64'({busy_o, out_valid_o}), 64'd0);
    @(negedge clock);

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      issue(op, a, b, ref_model(op, a, b), 1'b1);
    end
    drain();
    @(posedge clock); rand_bp = 1'b0;
    @(negedge clock);

    // Reset in the middle of an operation discards it
    issue(3'd7, 32'd999, 32'd10, 32'd0, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk(busy_o == 1'b0 && out_valid_o == 1'b0, "midop_reset_idle", 64'({busy_o, out_valid_o}), 64'd0);
    chk(result_o == 32'h0, "midop_reset_result", 64'(result_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk(in_ready_o == 1'b1 && busy_o == 1'b0, "midop_reset_release", 64'({in_ready_o, busy_o}), 64'b10);
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_fu.md
MULDIV_FU -- requirements
Module: muldiv_fu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; the only legal values are 32 and 64.
REQ-002 SHALL have ports: clock  in  1  system clock.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: flush_i  in  1  synchronous kill of any in-flight operation.
REQ-005 SHALL have ports: in_valid_i  in  1  operation offered; in_ready_o  out  1  unit can accept.
REQ-006 SHALL have ports: op_i  in  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports: src1_i, src2_i  in  XLEN  operands (src1 is the dividend / multiplicand).
REQ-008 SHALL have ports: out_valid_o  out  1  result available; out_ready_i  in  1  consumer takes result.
REQ-009 SHALL have ports: result_o  out  XLEN  result; busy_o  out  1  state != IDLE.

Function
REQ-010 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-011 SHALL drive in_ready_o = (state==IDLE) && !flush_i; an operation is accepted on a clock edge where in_valid_i && in_ready_o.
REQ-012 SHALL, on accept, latch op_i, record the operand signs, load the absolute values of the signed operands into working registers, and load the iteration counter with XLEN.
REQ-013 SHALL, in CALC, perform one radix-2 step per cycle (shift-add for multiply, shift-subtract-restore for divide), decrement the counter, and move to FIX when the counter reaches 1.
REQ-014 SHALL, in FIX, apply the sign correction, select the result, and move to DONE.
REQ-015 SHALL use these sign rules: product negative iff the signed-operand signs differ; quotient negative iff the signs differ; remainder sign follows the dividend.
REQ-016 SHALL return the low XLEN product bits for MUL and the high XLEN bits for MULH, MULHSU and MULHU; MULHSU treats src1 as signed and src2 as unsigned.
REQ-017 SHALL assert out_valid_o exactly XLEN+2 edges after the accepting edge for iterative operations.
REQ-018 SHALL go IDLE -> DONE in 1 edge for divide by zero: quotient all-ones, remainder = src1.
REQ-019 SHALL go IDLE -> DONE in 1 edge for signed overflow (src1 = most-negative, src2 = -1): quotient = src1, remainder 0.
REQ-020 SHALL hold result_o and out_valid_o stable in DONE until out_ready_i is high; DONE with out_ready_i high -> IDLE on the next edge.
REQ-021 SHALL NOT accept a new operation in the same cycle as the DONE handshake; the next accept is possible no earlier than the following cycle.
REQ-022 SHALL, on flush_i high, go to IDLE at the next edge from any state, drop out_valid_o, and produce no result; flush wins over a simultaneous in_valid_i.
REQ-023 SHALL ignore out_ready_i when out_valid_o is low.

Reset
REQ-024 SHALL, on reset low (asynchronous), force state IDLE, out_valid_o 0, result_o 0, counter 0 and all working registers 0.
REQ-025 SHALL, once released, see in_ready_o = 1 and busy_o = 0; a reset asserted mid-operation discards that operation with no output.

Configuration
REQ-026 SHALL honour macro MULDIV_FAST_MUL_EN.
REQ-027 SHALL, when MULDIV_FAST_MUL_EN is defined, compute all four multiply ops with a single-cycle combinational 2*XLEN multiplier, going IDLE -> DONE in 1 edge; divide is unchanged.
REQ-028 SHALL, when MULDIV_FAST_MUL_EN is undefined, compute multiply iteratively per REQ-013 and REQ-017 with no hardware multiplier.

Structure
REQ-029 SHALL place the op encodings MULDIV_OP_* (3 bits), the state encodings and the XLEN-independent constants in the shared defines file.
REQ-030 SHALL contain one sub-module, muldiv_step: the combinational single iteration (add/shift or subtract/restore), instantiated once.
REQ-031 SHALL be sized at 120-400 lines of RTL, excluding defines.

Verification (XLEN=32)
REQ-032 SHALL cover MUL: src1=7, src2=-3 -> result 0xFFFFFFEB after 34 edges (1 edge with MULDIV_FAST_MUL_EN).
REQ-033 SHALL cover MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU: -1 x 2 -> 0xFFFFFFFF.
REQ-034 SHALL cover DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each at 34 edges.
REQ-035 SHALL cover DIVU x/0 -> 0xFFFFFFFF and REM 0x80000000 / -1 -> 0, each with out_valid_o after 1 edge.
REQ-036 SHALL cover backpressure: out_ready_i held low for 5 cycles -> result_o stable, in_ready_o low throughout; release -> IDLE next edge.
REQ-037 SHALL cover flush at CALC cycle 10 -> IDLE next edge, no out_valid_o; a new DIVU 100/7 accepted next cycle -> 14.
